// File: rtl/he_pkg.sv
// he_pkg: shared definitions for the histogram-equalization sequencer.
//   he_state_t  - sequencer phases IDLE, CLEAR, HIST, CDF, MAP, DONE
//   NUM_BINS    - histogram / LUT depth (8-bit pixels -> 256 bins)
//   SCALE_SHIFT - fixed-point fraction bits of the CDF scale factor
package he_pkg;

  localparam int NUM_BINS    = 256;
  localparam int SCALE_SHIFT = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HIST,
    S_CDF,
    S_MAP,
    S_DONE
  } he_state_t;

endpackage

// File: rtl/he_hist_bank.sv
// he_hist_bank: 256 x CWIDTH histogram bin registers.
//   clk              in   clock, rising edge (bins are not reset)
//   clr_en/clr_idx   in   zero bin clr_idx this cycle (wins over increment)
//   inc_en/inc_idx   in   add one to bin inc_idx this cycle
//   rd_idx           in   combinational read index
//   rd_data          out  bins[rd_idx]
// The increment reads the current register value and writes the sum at the
// same edge, so back-to-back increments of one bin accumulate without any
// forwarding path.
module he_hist_bank
  import he_pkg::*;
#(
  parameter int CWIDTH = 20
) (
  input  logic              clk,
  input  logic              clr_en,
  input  logic [7:0]        clr_idx,
  input  logic              inc_en,
  input  logic [7:0]        inc_idx,
  input  logic [7:0]        rd_idx,
  output logic [CWIDTH-1:0] rd_data
);

  logic [CWIDTH-1:0] bins_q [NUM_BINS];

  logic              wr_en_d;
  logic [7:0]        wr_idx_d;
  logic [CWIDTH-1:0] wr_val_d;

  always_comb begin
    wr_en_d  = 1'b0;
    wr_idx_d = inc_idx;
    wr_val_d = bins_q[inc_idx] + CWIDTH'(1);
    if (clr_en) begin
      wr_en_d  = 1'b1;
      wr_idx_d = clr_idx;
      wr_val_d = '0;
    end else if (inc_en) begin
      wr_en_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) bins_q[wr_idx_d] <= wr_val_d;
  end

  assign rd_data = bins_q[rd_idx];

endmodule

// File: rtl/he_controller.sv
// he_controller: histogram-equalization sequencer owning the pixel BRAM port.
//   clk, rst        in   clock; asynchronous active-high reset
//   start           in   one-cycle request, honoured only in IDLE
//   busy            out  high while CLEAR/HIST/CDF/MAP are running
//   done            out  one-cycle pulse after the rewrite finishes
//   bram_we         out  BRAM write enable
//   bram_rd_en      out  BRAM read enable (start_he)
//   bram_addr       out  BRAM address (0 whenever no access is made)
//   bram_din        out  BRAM write data, lut[bram_dout] during write cycles
//   bram_dout       in   BRAM registered read data
// Optional macro HE_LUT_PORT_EN adds lut_rd_addr (in) / lut_rd_data (out),
// a combinational debug readout of the mapping LUT.
//
// BRAM handshake: a read issued with bram_rd_en=1 in cycle t returns data on
// bram_dout in cycle t+1; a write with bram_we=1 lands at the end of its
// cycle. bram_we and bram_rd_en are never high in the same cycle.
module he_controller
  import he_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int MEM_SIZE = 545920,
  parameter int AWIDTH   = 21,
  parameter int CWIDTH   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_we,
  output logic              bram_rd_en,
  output logic [AWIDTH-1:0] bram_addr,
  output logic [DWIDTH-1:0] bram_din,
  input  logic [DWIDTH-1:0] bram_dout
`ifdef HE_LUT_PORT_EN
  ,
  input  logic [7:0]        lut_rd_addr,
  output logic [7:0]        lut_rd_data
`endif
);

  localparam logic [AWIDTH-1:0] LAST_BIN  = AWIDTH'(NUM_BINS - 1);
  localparam logic [AWIDTH-1:0] MEM_END   = AWIDTH'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);
  // 255/MEM_SIZE in 24-bit fixed point; cdf*SCALE >> 24 maps cdf to 0..255.
  localparam logic [47:0]       SCALE     = (48'd255 << SCALE_SHIFT) / 48'(MEM_SIZE);

  he_state_t         state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              map_wr_q, map_wr_d;
  logic [CWIDTH-1:0] acc_q, acc_d;
  logic              rd_d1_q, rd_d1_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              rd_en_q, rd_en_d;
  logic [AWIDTH-1:0] addr_q, addr_d;

  logic [7:0]        lut_q [NUM_BINS];
  logic              lut_wr_en_d;
  logic [7:0]        lut_wr_idx_d;
  logic [7:0]        lut_wr_val_d;

  logic [CWIDTH-1:0] hist_rd;
  logic [CWIDTH-1:0] cdf_sum;
  logic [47:0]       prod;
  logic [47:0]       scaled;

  // The bin index doubles as the clear index and the CDF read index; the
  // increment fires in the cycle after each HIST read, when its data arrives.
  he_hist_bank #(.CWIDTH(CWIDTH)) u_hist (
    .clk     (clk),
    .clr_en  (state_q == S_CLEAR),
    .clr_idx (cnt_q[7:0]),
    .inc_en  ((state_q == S_HIST) && rd_d1_q),
    .inc_idx (bram_dout),
    .rd_idx  (cnt_q[7:0]),
    .rd_data (hist_rd)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    map_wr_d     = map_wr_q;
    acc_d        = acc_q;
    rd_d1_d      = rd_en_q;
    cdf_sum      = acc_q + hist_rd;
    prod         = 48'(cdf_sum) * SCALE;
    scaled       = prod >> SCALE_SHIFT;
    lut_wr_en_d  = 1'b0;
    lut_wr_idx_d = cnt_q[7:0];
    lut_wr_val_d = (scaled > 48'd255) ? 8'hFF : scaled[7:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_BIN) begin
          state_d = S_HIST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      S_HIST: begin
        // cnt_q == MEM_END is the drain cycle for the final read's data.
        if (cnt_q == MEM_END) begin
          state_d = S_CDF;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      S_CDF: begin
        acc_d       = cdf_sum;
        lut_wr_en_d = 1'b1;
        if (cnt_q == LAST_BIN) begin
          state_d  = S_MAP;
          cnt_d    = '0;
          map_wr_d = 1'b0;
        end else begin
          cnt_d = cnt_q + AWIDTH'(1);
        end
      end
      S_MAP: begin
        if (!map_wr_q) begin
          map_wr_d = 1'b1;
        end else begin
          map_wr_d = 1'b0;
          if (cnt_q == LAST_ADDR) state_d = S_DONE;
          else                    cnt_d   = cnt_q + AWIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    rd_en_d = ((state_d == S_HIST) && (cnt_d < MEM_END)) ||
              ((state_d == S_MAP) && !map_wr_d);
    we_d    = (state_d == S_MAP) && map_wr_d;
    addr_d  = (rd_en_d || we_d) ? cnt_d : '0;
    busy_d  = state_d inside {S_CLEAR, S_HIST, S_CDF, S_MAP};
    // done trails the DONE state by one cycle, as the state returns to IDLE.
    done_d  = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      map_wr_q <= 1'b0;
      acc_q    <= '0;
      rd_d1_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      map_wr_q <= map_wr_d;
      acc_q    <= acc_d;
      rd_d1_q  <= rd_d1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lut_wr_en_d) lut_q[lut_wr_idx_d] <= lut_wr_val_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bram_we    = we_q;
  assign bram_rd_en = rd_en_q;
  assign bram_addr  = addr_q;
  // The pixel read in the previous cycle sits on the BRAM's output register
  // during the write cycle, so the LUT lookup is taken straight from it.
  assign bram_din   = we_q ? lut_q[bram_dout] : '0;

`ifdef HE_LUT_PORT_EN
  assign lut_rd_data = lut_q[lut_rd_addr];
`endif

endmodule

// File: tb/tb_he_controller.sv
module tb_he_controller;

  localparam int M   = 16;
  localparam int AW  = 21;
  localparam int LAT = 1 + 256 + (M + 1) + 256 + 2 * M;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, bram_we, bram_rd_en;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_din;
  logic [7:0]    bram_dout;

  he_controller #(.DWIDTH(8), .MEM_SIZE(M), .AWIDTH(AW), .CWIDTH(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .bram_we    (bram_we),
    .bram_rd_en (bram_rd_en),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout)
`ifdef HE_LUT_PORT_EN
    ,
    .lut_rd_addr (8'd0),
    .lut_rd_data ()
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- BRAM model ----------------
  logic [7:0] mem      [M];
  logic [7:0] load_img [M];
  logic       load_en = 1'b0;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < M; i++) mem[i] <= load_img[i];
    end else begin
      if (bram_we) mem[bram_addr[3:0]] <= bram_din;
      if (bram_rd_en) bram_dout <= mem[bram_addr[3:0]];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];   // {addr[7:0], expected pixel} per write
  int          lat_q[$];   // expected start-to-done latency per accepted pass
  int          start_cyc = 0;
  int          done_cnt  = 0;

  logic [7:0] cur_img [M];
  logic [7:0] exp_img [M];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: histogram -> cumulative counts -> scaled, clamped LUT.
  task automatic compute_expect();
    int     hist [256];
    logic [7:0] lut [256];
    longint scale;
    longint acc;
    longint v;
    scale = (longint'(255) << 24) / M;
    for (int b = 0; b < 256; b++) hist[b] = 0;
    for (int a = 0; a < M; a++) hist[cur_img[a]]++;
    acc = 0;
    for (int b = 0; b < 256; b++) begin
      acc += hist[b];
      v = (acc * scale) >> 24;
      lut[b] = (v > 255) ? 8'd255 : 8'(v);
    end
    for (int a = 0; a < M; a++) exp_img[a] = lut[cur_img[a]];
  endtask

  // Monitor: protocol, write data and done latency, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (bram_we || bram_rd_en) begin
      check("we_rd_exclusive", {31'd0, bram_we & bram_rd_en}, 0);
      check("addr_range", {31'd0, bram_addr < AW'(M)}, 1);
    end
    if (bram_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, bram_addr[7:0]}, 32'hFFFF);
      end else begin
        check("write_addr_data", {16'd0, bram_addr[7:0], bram_din}, {16'd0, exp_q.pop_front()});
      end
    end
    if (done) begin
      done_cnt++;
      if (lat_q.size() == 0) check("unexpected_done", 1, 0);
      else                   check("done_latency", cyc - start_cyc, lat_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_image();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic issue_start();
    for (int a = 0; a < M; a++) cur_img[a] = mem[a];
    compute_expect();
    for (int a = 0; a < M; a++) exp_q.push_back({8'(a), exp_img[a]});
    lat_q.push_back(LAT);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 1);
  endtask

  task automatic run_pass(input bit interfere);
    int  d0;
    bit  seen;
    issue_start();
    d0 = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < LAT + 50 && !seen; k++) begin
      @(negedge clk);
      start = interfere && ((cyc - start_cyc == 260) || (cyc - start_cyc == 540));
      if (done_cnt != d0) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", {31'd0, seen}, 1);
    repeat (4) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("writes_drained", exp_q.size(), 0);
    check("busy_low", {31'd0, busy}, 0);
    for (int a = 0; a < M; a++) check("bram_final", {24'd0, mem[a]}, {24'd0, exp_img[a]});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},   {31'd0, bram_we}, 0);
    check({tag, "_rd"},   {31'd0, bram_rd_en}, 0);
    check({tag, "_addr"}, {11'd0, bram_addr}, 0);
    check({tag, "_din"},  {24'd0, bram_din}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #2;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All pixels equal: every pixel maps to 255.
    for (int a = 0; a < M; a++) load_img[a] = 8'd7;
    load_image();
    run_pass(1'b0);

    // Ramp 0..15: cdf(i)=i+1.
    for (int a = 0; a < M; a++) load_img[a] = 8'(a);
    load_image();
    run_pass(1'b0);

    // Two-level image: 12 x 200, 4 x 10 -> 255 / 63.
    for (int a = 0; a < M; a++) load_img[a] = (a % 4 == 3) ? 8'd10 : 8'd200;
    load_image();
    run_pass(1'b0);

    // Random images: full range and a narrow range with many repeats.
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < M; a++)
        load_img[a] = (r == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      load_image();
      run_pass(1'b0);
    end

    // start pulses during HIST and MAP are ignored.
    for (int a = 0; a < M; a++) load_img[a] = 8'($urandom_range(20, 90));
    load_image();
    run_pass(1'b1);

    // Reset in the middle of MAP, then a full pass over the partial result.
    for (int a = 0; a < M; a++) load_img[a] = 8'($urandom_range(0, 255));
    load_image();
    issue_start();
    while (cyc - start_cyc < 545) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_pass(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
